// File: rtl/pc_fetch_stage_pkg.sv
// Purpose : shared fetch-stage types and constants (FSM encoding, PC increment).
// Latency : n/a (definitions only).
// Backpr. : n/a.
package pc_fetch_stage_pkg;

  // Fetch sequencer states. The encodings are fixed so that debug views and
  // external tooling can decode the raw 2-bit state value.
  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_FETCH = 2'd1,
    FS_VALID = 2'd2,
    FS_ERR   = 2'd3
  } fetch_state_e;

  // Sequential-path PC increment (one 32-bit instruction word).
  localparam logic [31:0] PC_INCR = 32'd4;

  // A PC is usable only if it points at a word boundary.
  function automatic logic pc_aligned(input logic [1:0] pc_lsb);
    return (pc_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_stage_pc_reg_32.sv
// Purpose : 32-bit program-counter register with load enable.
// Latency : 1 cycle from d/load to q.
// Backpr. : none; the caller decides when to load.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset, q <= RESET_PC
//   load   in   1   capture d on the next rising edge
//   d      in   32  next PC value
//   q      out  32  current PC value
module pc_reg_32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// Purpose : PC register plus fetch sequencer: fetch one word per PC, hand it to decode.
// Latency : retire -> imem_req 1 cycle; imem_ack -> instr_valid 1 cycle (2 cycles/instr best case).
// Backpr. : decode holds instr_valid via instr_ready=0 or stall=1; memory stalls fetch by delaying imem_ack.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   next_pc      in   32  target PC from the PC-source mux
//   pc_load      in   1   on retire: 1 takes next_pc, 0 takes pc_plus4
//   stall        in   1   hazard stall, blocks retire (ignored while fetching)
//   imem_req     out  1   instruction-memory read request
//   imem_addr    out  32  read address (equals pc_out)
//   imem_ack     in   1   memory response, imem_rdata valid in the same cycle
//   imem_rdata   in   32  fetched instruction word
//   instr_out    out  32  registered instruction for decode
//   instr_valid  out  1   instr_out holds the instruction at pc_out
//   instr_ready  in   1   decode accepts instr_out
//   pc_out       out  32  current PC
//   pc_plus4     out  32  pc_out + 4, combinational, wraps modulo 2^32
//   misalign_err out  1   sticky: a non-word-aligned PC was computed
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000  // must be word-aligned
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        pc_load,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        misalign_err
);

  fetch_state_e state_q;
  fetch_state_e state_d;

  logic        retire;
  logic        capture;
  logic [31:0] pc_new;

  // ---------------------------------------------------------------------------
  // PC datapath
  // ---------------------------------------------------------------------------
  assign pc_plus4 = pc_out + PC_INCR;

  // pc_load only matters on the retire cycle because that is the only cycle
  // the PC register is enabled.
  assign pc_new = pc_load ? next_pc : pc_plus4;

  // stall outranks instr_ready; outside VALID neither has any effect.
  assign retire  = (state_q == FS_VALID) && instr_ready && !stall;

  // Only a FETCH-state ack carries our instruction. Acks in BOOT (a response
  // left over from before reset) or in VALID/ERR are stray and dropped.
  assign capture = (state_q == FS_FETCH) && imem_ack;

  pc_reg_32 #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (retire),
    .d     (pc_new),
    .q     (pc_out)
  );

  // ---------------------------------------------------------------------------
  // Instruction register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_out <= 32'h0000_0000;
    end else if (capture) begin
      instr_out <= imem_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      // One idle cycle after reset so a response still in flight from before
      // reset cannot be mistaken for the first fetch.
      FS_BOOT:  state_d = FS_FETCH;
      FS_FETCH: if (capture) state_d = FS_VALID;
      // The PC register takes the bad value as well, so pc_out shows the
      // offending target once we land in ERR.
      FS_VALID: if (retire) state_d = pc_aligned(pc_new[1:0]) ? FS_FETCH : FS_ERR;
      FS_ERR:   state_d = FS_ERR;
    endcase
  end

  // All handshake outputs are pure decodes of the state register, so they are
  // glitch-free and never depend combinationally on this cycle's inputs.
  // ERR is terminal until reset, which makes the error flag sticky.
  assign imem_req     = (state_q == FS_FETCH);
  assign imem_addr    = pc_out;
  assign instr_valid  = (state_q == FS_VALID);
  assign misalign_err = (state_q == FS_ERR);

endmodule

// File: tb/tb_pc_fetch_stage.sv
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] next_pc = '0;
  logic        pc_load = 1'b0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        misalign_err;

  int checks = 0;
  int failures = 0;

  pc_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .next_pc      (next_pc),
    .pc_load      (pc_load),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // Everything happens just after a falling edge: outputs are sampled there
  // and inputs set there take effect at the following rising edge.

  task automatic go_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0; pc_load = 1'b0;
    next_pc = '0; instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Waits for a request, answers it zero-wait; returns in the VALID window.
  task automatic serve(input logic [31:0] data, output bit ok);
    wait_req(ok);
    imem_ack = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_ack = 1'b0; stall = 1'b0; pc_load = 1'b0; instr_ready = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b want 0", misalign_err); end
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h want 0", pc_out); end
    checks++; if (instr_out !== 32'h0) begin failures++; $display("FAIL rst_instr: got %h want 0", instr_out); end
    checks++; if (pc_plus4 !== 32'h4) begin failures++; $display("FAIL rst_pc_plus4: got %h want 4", pc_plus4); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Follows test_reset directly: we are in the BOOT cycle.
  task automatic test_zero_wait();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; instr_ready = 1'b1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL zw_boot_req: got %b want 0", imem_req); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL zw_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL zw_addr: got %h want 0", imem_addr); end
    checks++; if (instr_out !== 32'h0) begin failures++; $display("FAIL zw_boot_ack_ignored: got %h want 0", instr_out); end
    imem_rdata = 32'h2008_0005;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL zw_valid: got %b want 1", instr_valid); end
    checks++; if (instr_out !== 32'h2008_0005) begin failures++; $display("FAIL zw_instr: got %h want 20080005", instr_out); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL zw_req_drop: got %b want 0", imem_req); end
    @(negedge clk);
    checks++; if (pc_out !== 32'h4) begin failures++; $display("FAIL zw_pc: got %h want 4", pc_out); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL zw_refetch: got %b want 1", imem_req); end
  endtask

  task automatic test_sequential();
    bit ok;
    logic [31:0] d;
    go_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_req(ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL seq_req_timeout: step %0d no request", i); end
      checks++; if (imem_addr !== 32'(i * 4)) begin failures++; $display("FAIL seq_addr: step %0d got %h want %h", i, imem_addr, 32'(i * 4)); end
      if (i < 4) begin
        d = $urandom;
        imem_ack = 1'b1; imem_rdata = d;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (instr_out !== d) begin failures++; $display("FAIL seq_instr: step %0d got %h want %h", i, instr_out, d); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_branch();
    bit ok;
    go_reset();
    instr_ready = 1'b1;
    serve(32'h1, ok); @(negedge clk);
    serve(32'h2, ok); @(negedge clk);
    serve(32'h3, ok);
    checks++; if (pc_out !== 32'h8) begin failures++; $display("FAIL br_pc_before: got %h want 8", pc_out); end
    pc_load = 1'b1; next_pc = 32'h40;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h40) begin failures++; $display("FAIL br_addr: got %h want 40", imem_addr); end
    checks++; if (pc_plus4 !== 32'h44) begin failures++; $display("FAIL br_pc_plus4: got %h want 44", pc_plus4); end
    // pc_load held high through FETCH must not matter; dropped on the retire cycle.
    next_pc = 32'h80;
    repeat (2) @(negedge clk);
    serve(32'h4, ok);
    pc_load = 1'b0;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h44) begin failures++; $display("FAIL br_pc_load_ignored: got %h want 44", imem_addr); end
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] d;
    go_reset();
    instr_ready = 1'b1;
    d = $urandom;
    serve(d, ok);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL stall_pc: cycle %0d got %h want 0", i, pc_out); end
      checks++; if (instr_out !== d) begin failures++; $display("FAIL stall_instr: cycle %0d got %h want %h", i, instr_out, d); end
      checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL stall_valid: cycle %0d got %b want 1", i, instr_valid); end
    end
    stall = 1'b0;
    @(negedge clk);
    checks++; if (pc_out !== 32'h4) begin failures++; $display("FAIL stall_release_pc: got %h want 4", pc_out); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL stall_release_req: got %b want 1", imem_req); end
  endtask

  task automatic test_mem_wait();
    bit ok;
    logic [31:0] d;
    go_reset();
    instr_ready = 1'b1;
    stall = 1'b1;  // no effect while fetching
    wait_req(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mw_req_timeout: no request"); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL mw_hold: cycle %0d req %b addr %h want 1/0", i, imem_req, imem_addr); end
      @(negedge clk);
    end
    d = $urandom;
    imem_ack = 1'b1; imem_rdata = d;
    @(negedge clk);
    imem_ack = 1'b0; stall = 1'b0; instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr_out !== d) begin failures++; $display("FAIL mw_capture: valid %b instr %h want 1/%h", instr_valid, instr_out, d); end
    imem_ack = 1'b1; imem_rdata = ~d;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++; if (instr_out !== d) begin failures++; $display("FAIL mw_stray_ack: got %h want %h", instr_out, d); end
    checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL mw_stray_state: valid %b req %b want 1/0", instr_valid, imem_req); end
    instr_ready = 1'b1;
    @(negedge clk);
    checks++; if (pc_out !== 32'h4) begin failures++; $display("FAIL mw_retire_pc: got %h want 4", pc_out); end
  endtask

  task automatic test_errors();
    bit ok;
    go_reset();
    instr_ready = 1'b1;
    serve(32'h1234_5678, ok);
    pc_load = 1'b1; next_pc = 32'h102;
    @(negedge clk);
    pc_load = 1'b0;
    checks++; if (misalign_err !== 1'b1) begin failures++; $display("FAIL err_flag: got %b want 1", misalign_err); end
    checks++; if (pc_out !== 32'h102) begin failures++; $display("FAIL err_pc: got %h want 102", pc_out); end
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL err_outputs: req %b valid %b want 0/0", imem_req, instr_valid); end
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1;
      @(negedge clk);
      checks++; if (imem_req !== 1'b0 || misalign_err !== 1'b1) begin failures++; $display("FAIL err_terminal: cycle %0d req %b err %b want 0/1", i, imem_req, misalign_err); end
    end
    imem_ack = 1'b0;

    // asynchronous reset in the middle of a fetch
    go_reset();
    instr_ready = 1'b1;
    serve(32'h1, ok);
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || pc_out !== 32'h4) begin failures++; $display("FAIL arst_setup: req %b pc %h want 1/4", imem_req, pc_out); end
    #2; rst_n = 1'b0; #1;
    checks++; if (pc_out !== 32'h0 || imem_req !== 1'b0 || instr_out !== 32'h0) begin failures++; $display("FAIL arst_immediate: pc %h req %b instr %h want 0/0/0", pc_out, imem_req, instr_out); end
    imem_ack = 1'b1;  // in-flight response arriving around reset
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_out !== 32'h0) begin failures++; $display("FAIL arst_restart: req %b addr %h instr %h want 1/0/0", imem_req, imem_addr, instr_out); end

    // wrap-around from the top of the address space
    serve(32'h5, ok);
    pc_load = 1'b1; next_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    pc_load = 1'b0;
    checks++; if (pc_out !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_setup: pc %h plus4 %h want fffffffc/0", pc_out, pc_plus4); end
    serve(32'h6, ok);
    @(negedge clk);
    checks++; if (pc_out !== 32'h0 || misalign_err !== 1'b0 || imem_req !== 1'b1) begin failures++; $display("FAIL wrap_retire: pc %h err %b req %b want 0/0/1", pc_out, misalign_err, imem_req); end
  endtask

  // Transaction-level model: expected PC advances only when decode takes an
  // instruction; everything else must leave the visible state untouched.
  task automatic test_random();
    bit ok;
    logic [31:0] exp_pc;
    logic [31:0] d;
    int delay;
    bit r, s, pl;
    logic [31:0] np;
    go_reset();
    exp_pc = 32'h0;
    for (int n = 0; n < 40; n++) begin
      wait_req(ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rnd_req_timeout: txn %0d", n); end
      delay = $urandom_range(0, 3);
      for (int w = 0; w < delay; w++) begin
        stall = 1'($urandom_range(0, 1));
        instr_ready = 1'($urandom_range(0, 1));
        checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin failures++; $display("FAIL rnd_wait: txn %0d req %b addr %h want 1/%h", n, imem_req, imem_addr, exp_pc); end
        @(negedge clk);
      end
      checks++; if (imem_addr !== exp_pc) begin failures++; $display("FAIL rnd_addr: txn %0d got %h want %h", n, imem_addr, exp_pc); end
      d = $urandom;
      imem_ack = 1'b1; imem_rdata = d;
      @(negedge clk);
      imem_ack = 1'b0;
      checks++; if (instr_valid !== 1'b1 || instr_out !== d || pc_out !== exp_pc) begin failures++; $display("FAIL rnd_deliver: txn %0d valid %b instr %h pc %h want 1/%h/%h", n, instr_valid, instr_out, pc_out, d, exp_pc); end
      for (int c = 0; c < 16; c++) begin
        r  = (c == 15) ? 1'b1 : 1'($urandom_range(0, 1));
        s  = (c == 15) ? 1'b0 : ($urandom_range(0, 3) == 0);
        pl = 1'($urandom_range(0, 1));
        np = $urandom & 32'hFFFF_FFFC;
        instr_ready = r; stall = s; pc_load = pl; next_pc = np;
        imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
        @(negedge clk);
        imem_ack = 1'b0;
        if (r && !s) begin
          exp_pc = pl ? np : exp_pc + 32'd4;
          checks++; if (pc_out !== exp_pc || imem_req !== 1'b1 || instr_valid !== 1'b0) begin failures++; $display("FAIL rnd_retire: txn %0d pc %h req %b valid %b want %h/1/0", n, pc_out, imem_req, instr_valid, exp_pc); end
          break;
        end else begin
          checks++; if (pc_out !== exp_pc || instr_out !== d || instr_valid !== 1'b1) begin failures++; $display("FAIL rnd_hold: txn %0d pc %h instr %h valid %b want %h/%h/1", n, pc_out, instr_out, instr_valid, exp_pc, d); end
        end
      end
      pc_load = 1'b0;
    end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL rnd_no_err: got %b want 0", misalign_err); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_sequential();
    test_branch();
    test_stall();
    test_mem_wait();
    test_errors();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
